// File: rtl/overlap_add_synth_if.sv
// overlap_add_synth_if: stream bundle for the overlap-add synthesis stage.
//   in_sample / in_first_in / in_valid_in / in_ready_out : windowed frame input
//   flush_in                                             : drain the stored tail
//   out_sample / out_valid_out / out_ready_in            : reconstructed output
//   err_out                                              : sticky frame-alignment error
// master = upstream/downstream environment, slave = overlap_add_synth.
interface overlap_add_synth_if #(
  parameter int DATA_WIDTH = 8
);
  logic signed [DATA_WIDTH-1:0] in_sample;
  logic                         in_first_in;
  logic                         in_valid_in;
  logic                         in_ready_out;
  logic                         flush_in;
  logic signed [DATA_WIDTH:0]   out_sample;
  logic                         out_valid_out;
  logic                         out_ready_in;
  logic                         err_out;

  modport master (
    output in_sample, in_first_in, in_valid_in, flush_in, out_ready_in,
    input  in_ready_out, out_sample, out_valid_out, err_out
  );

  modport slave (
    input  in_sample, in_first_in, in_valid_in, flush_in, out_ready_in,
    output in_ready_out, out_sample, out_valid_out, err_out
  );
endinterface

// File: rtl/overlap_add_synth.sv
// overlap_add_synth: overlap-add reconstruction of 50%-overlapped windowed
// frames. First half of each frame is summed with the stored second half of
// the previous frame and emitted; second half is stored as the new tail.
// A flush request at a frame boundary drains the stored tail.
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : asynchronous active-low reset
//   bus     : overlap_add_synth_if.slave (input stream, flush, output stream, err)
// Parameters: DATA_WIDTH (input width), FRAME_LEN (power of two, >= 4).
// Optional feature macro: OLA_FRAME_ERR_EN enables in_first_in resync and err_out;
// undefined, in_first_in is ignored and err_out is tied low.
module overlap_add_synth #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4096
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  overlap_add_synth_if.slave   bus
);

  localparam int HOP   = FRAME_LEN / 2;
  localparam int IDX_W = $clog2(HOP);

  localparam logic [1:0] ST_FIRST  = 2'd0;
  localparam logic [1:0] ST_SECOND = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  // HOP is a power of two, so the last index is all ones.
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [1:0]                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       primed_q, primed_d;
  logic signed [DATA_WIDTH:0] out_q, out_d;
  logic                       out_valid_q, out_valid_d;

  logic signed [DATA_WIDTH-1:0] tail_q [HOP];
  logic signed [DATA_WIDTH-1:0] rd_q;
  logic                         wr_en;

  logic                       out_free;
  logic                       ready;
  logic                       at_origin;
  logic                       flush_take;
  logic                       accept;
  logic                       resync;
  logic signed [DATA_WIDTH:0] in_ext;
  logic signed [DATA_WIDTH:0] tail_ext;
  logic signed [DATA_WIDTH:0] tail_term;
  logic signed [DATA_WIDTH:0] sum;

  assign out_free   = !out_valid_q || bus.out_ready_in;
  assign at_origin  = (state_q == ST_FIRST) && (idx_q == '0);
  assign flush_take = bus.flush_in && at_origin && primed_q;
  assign accept     = bus.in_valid_in && ready && !flush_take;
  assign in_ext     = {bus.in_sample[DATA_WIDTH-1], bus.in_sample};

`ifdef OLA_FRAME_ERR_EN
  logic                         err_q, err_d;
  logic signed [DATA_WIDTH-1:0] tail0_q;

  assign resync = accept && bus.in_first_in && !at_origin;
  // Resync jumps to index 0 without a pre-read, so tail[0] is shadowed here.
  assign tail_ext = resync ? {tail0_q[DATA_WIDTH-1], tail0_q}
                           : {rd_q[DATA_WIDTH-1], rd_q};
  assign bus.err_out = err_q;
`else
  assign resync      = 1'b0;
  assign tail_ext    = {rd_q[DATA_WIDTH-1], rd_q};
  assign bus.err_out = 1'b0;
`endif

  assign tail_term = primed_q ? tail_ext : '0;
  assign sum       = in_ext + tail_term;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_FIRST:  ready = out_free;
`ifdef OLA_FRAME_ERR_EN
      // A resync in the second half emits a word, so it must wait for the
      // output register like any first-half sample.
      ST_SECOND: ready = !(bus.in_valid_in && bus.in_first_in && !out_free);
`else
      ST_SECOND: ready = 1'b1;
`endif
      default:   ready = 1'b0;
    endcase
  end

  assign bus.in_ready_out  = ready;
  assign bus.out_sample    = out_q;
  assign bus.out_valid_out = out_valid_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    primed_d    = primed_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !bus.out_ready_in;
    wr_en       = 1'b0;
`ifdef OLA_FRAME_ERR_EN
    err_d       = err_q || resync;
`endif
    if (flush_take) begin
      state_d = ST_FLUSH;
      idx_d   = '0;
    end else if (accept && resync) begin
      out_d       = sum;
      out_valid_d = 1'b1;
      state_d     = ST_FIRST;
      idx_d       = IDX_ONE;
    end else if (accept) begin
      if (state_q == ST_FIRST) begin
        out_d       = sum;
        out_valid_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_SECOND;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end else begin
        wr_en = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d  = ST_FIRST;
          idx_d    = '0;
          primed_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
    end else if (state_q == ST_FLUSH && out_free) begin
      out_d       = {rd_q[DATA_WIDTH-1], rd_q};
      out_valid_d = 1'b1;
      if (idx_q == IDX_LAST) begin
        state_d  = ST_FIRST;
        idx_d    = '0;
        primed_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_FIRST;
      idx_q       <= '0;
      primed_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      primed_q    <= primed_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef OLA_FRAME_ERR_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  // Tail storage is not reset; primed_q masks stale contents. The read
  // address is the next index so rd_q holds tail[idx_q] in the accept cycle.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tail_q[idx_q] <= bus.in_sample;
    end
    rd_q <= tail_q[idx_d];
  end

`ifdef OLA_FRAME_ERR_EN
  always_ff @(posedge clk_in) begin
    if (wr_en && idx_q == '0) begin
      tail0_q <= bus.in_sample;
    end
  end
`endif

endmodule
